// File: rtl/difftest_fpwb_pkg.sv
// Shared constants and the queued entry type for the FP writeback serializer.
package difftest_fpwb_pkg;

    localparam int FPWB_NUM_PORTS = 4;
    localparam int FPWB_DEPTH     = 16;
    localparam int FP_IDX_W       = 5;

    typedef struct packed {
        logic [FP_IDX_W-1:0] dest;
        logic [63:0]         data;
    } fpwb_entry_t;

endpackage

// File: rtl/fpwb_fifo.sv
// Circular buffer accepting up to NUM_PORTS pre-compacted entries per cycle and
// releasing at most one from the head; storage itself is not reset.
module fpwb_fifo
    import difftest_fpwb_pkg::*;
#(
    parameter int NUM_PORTS = FPWB_NUM_PORTS,
    parameter int DEPTH     = FPWB_DEPTH
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [$clog2(NUM_PORTS+1)-1:0] push_cnt,
    input  fpwb_entry_t                   push_data [NUM_PORTS],
    input  logic                          pop,
    output fpwb_entry_t                   head,
    output logic [$clog2(DEPTH+1)-1:0]    count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int PW = $clog2(NUM_PORTS+1);

    fpwb_entry_t       mem_q [DEPTH];
    fpwb_entry_t       mem_d [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              pop_s;

    // Next-state: write the compacted group at the write pointer (wrapping naturally).
    always_comb begin
        mem_d = mem_q;
        pop_s = pop & (count_q != '0);
        for (int j = 0; j < NUM_PORTS; j++) begin
            logic [AW-1:0] idx;
            idx        = wr_ptr_q + AW'(j);
            mem_d[idx] = (PW'(j) < push_cnt) ? push_data[j] : mem_q[idx];
        end
        wr_ptr_d = wr_ptr_q + AW'(push_cnt);
        rd_ptr_d = rd_ptr_q + AW'(pop_s);
        count_d  = count_q + CW'(push_cnt) - CW'(pop_s);
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage.
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/difftest_fp_wb_serializer.sv
// Serializes per-cycle FP writeback events into a single ordered stream.
// Optional DIFFTEST_FPWB_OVERFLOW_ASSERT_EN adds a simulation check on dropped groups.
`ifdef DIFFTEST_FPWB_OVERFLOW_ASSERT_EN
module fpwb_overflow_checker #(
    parameter int PW = 3
) (
    input logic          clock,
    input logic          reset,
    input logic          drop,
    input logic [PW-1:0] drop_cnt
);
    logic [63:0] cycle_q;

    // Cycle counter and drop report.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cycle_q <= 64'd0;
        end else begin
            cycle_q <= cycle_q + 64'd1;
            if (drop) begin
                $error("fpwb: group dropped at cycle %0d, %0d events lost", cycle_q, drop_cnt);
            end
        end
    end
endmodule
`endif

module difftest_fp_wb_serializer
    import difftest_fpwb_pkg::*;
#(
    parameter int NUM_PORTS = FPWB_NUM_PORTS,
    parameter int DEPTH     = FPWB_DEPTH
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [7:0]                     io_coreid,
    input  logic [NUM_PORTS-1:0]           io_in_valid,
    input  logic [NUM_PORTS*FP_IDX_W-1:0]  io_in_dest,
    input  logic [NUM_PORTS*64-1:0]        io_in_data,
    input  logic                           io_out_ready,
    output logic                           io_out_valid,
    output logic [7:0]                     io_out_coreid,
    output logic [31:0]                    io_out_dest,
    output logic [63:0]                    io_out_data,
    output logic [$clog2(DEPTH+1)-1:0]     io_count,
    output logic                           io_overflow
);

    localparam int CW = $clog2(DEPTH+1);
    localparam int PW = $clog2(NUM_PORTS+1);
    localparam int IW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    fpwb_entry_t   comp_s [NUM_PORTS];
    fpwb_entry_t   head_s;
    logic [PW-1:0] push_cnt_s;
    logic [PW-1:0] enq_cnt_s;
    logic [CW-1:0] count_s;
    logic [CW-1:0] free_s;
    logic          drop_s;
    logic          pop_s;
    logic          overflow_q, overflow_d;

    // Compaction: valid ports packed in ascending order; free space ignores this cycle's pop.
    always_comb begin
        comp_s     = '{default: '0};
        push_cnt_s = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (io_in_valid[i]) begin
                comp_s[push_cnt_s[IW-1:0]] = '{dest: io_in_dest[i*FP_IDX_W +: FP_IDX_W],
                                               data: io_in_data[i*64 +: 64]};
                push_cnt_s = push_cnt_s + PW'(1);
            end else begin
                push_cnt_s = push_cnt_s;
            end
        end
        free_s     = CW'(DEPTH) - count_s;
        drop_s     = CW'(push_cnt_s) > free_s;
        enq_cnt_s  = drop_s ? '0 : push_cnt_s;
        pop_s      = (count_s != '0) & io_out_ready;
        overflow_d = overflow_q | drop_s;
    end

    // Sticky overflow flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    fpwb_fifo #(
        .NUM_PORTS (NUM_PORTS),
        .DEPTH     (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push_cnt  (enq_cnt_s),
        .push_data (comp_s),
        .pop       (pop_s),
        .head      (head_s),
        .count     (count_s)
    );

`ifdef DIFFTEST_FPWB_OVERFLOW_ASSERT_EN
    fpwb_overflow_checker #(
        .PW (PW)
    ) u_ovf_chk (
        .clock    (clock),
        .reset    (reset),
        .drop     (drop_s),
        .drop_cnt (push_cnt_s)
    );
`else
    // Drops are recorded only by io_overflow in this build.
`endif

    assign io_out_valid  = (count_s != '0);
    assign io_out_coreid = io_coreid;
    assign io_out_dest   = {{(32-FP_IDX_W){1'b0}}, head_s.dest};
    assign io_out_data   = head_s.data;
    assign io_count      = count_s;
    assign io_overflow   = overflow_q;

endmodule

// File: tb/tb_difftest_fp_wb_serializer.sv
// Directed self-checking bench for difftest_fp_wb_serializer (4 ports, depth 16).
module tb_difftest_fp_wb_serializer;

    logic         clock;
    logic         reset;
    logic [7:0]   io_coreid;
    logic [3:0]   io_in_valid;
    logic [19:0]  io_in_dest;
    logic [255:0] io_in_data;
    logic         io_out_ready;
    logic         io_out_valid;
    logic [7:0]   io_out_coreid;
    logic [31:0]  io_out_dest;
    logic [63:0]  io_out_data;
    logic [4:0]   io_count;
    logic         io_overflow;

    int checks;
    int errors;

    difftest_fp_wb_serializer dut (
        .clock         (clock),
        .reset         (reset),
        .io_coreid     (io_coreid),
        .io_in_valid   (io_in_valid),
        .io_in_dest    (io_in_dest),
        .io_in_data    (io_in_data),
        .io_out_ready  (io_out_ready),
        .io_out_valid  (io_out_valid),
        .io_out_coreid (io_out_coreid),
        .io_out_dest   (io_out_dest),
        .io_out_data   (io_out_data),
        .io_count      (io_count),
        .io_overflow   (io_overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Present one group for a single edge: port p carries dest base_dest+p, data base_data+p.
    task automatic drive_group(input logic [3:0] v, input int base_dest, input logic [63:0] base_data);
        io_in_valid = v;
        for (int p = 0; p < 4; p++) begin
            io_in_dest[p*5 +: 5]  = 5'(base_dest + p);
            io_in_data[p*64 +: 64] = base_data + 64'(p);
        end
        @(posedge clock);
        #1;
        io_in_valid = 4'b0000;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset        = 1'b1;
        io_coreid    = 8'h5A;
        io_in_valid  = 4'b0000;
        io_in_dest   = 20'd0;
        io_in_data   = 256'd0;
        io_out_ready = 1'b1;
        #2;
        checks++; if (io_count !== 5'd0) begin errors++; $display("FAIL reset_count got %0d want 0", io_count); end
        checks++; if (io_out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", io_out_valid); end
        checks++; if (io_overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", io_overflow); end
        checks++; if (io_out_coreid !== 8'h5A) begin errors++; $display("FAIL coreid got %h want 5a", io_out_coreid); end
        do_reset();
    endtask

    task automatic test_single();
        io_out_ready = 1'b1;
        io_in_valid  = 4'b0100;
        io_in_dest[10 +: 5]   = 5'd5;
        io_in_data[128 +: 64] = 64'h3FF0000000000000;
        @(posedge clock);
        #1;
        io_in_valid = 4'b0000;
        checks++; if (io_out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b want 1", io_out_valid); end
        checks++; if (io_out_dest !== 32'd5) begin errors++; $display("FAIL single_dest got %0d want 5", io_out_dest); end
        checks++; if (io_out_data !== 64'h3FF0000000000000) begin errors++; $display("FAIL single_data got %h want 3ff0000000000000", io_out_data); end
        @(posedge clock);
        #1;
        checks++; if (io_out_valid !== 1'b0) begin errors++; $display("FAIL single_drain_valid got %b want 0", io_out_valid); end
        checks++; if (io_count !== 5'd0) begin errors++; $display("FAIL single_drain_count got %0d want 0", io_count); end
    endtask

    task automatic test_order();
        io_out_ready = 1'b1;
        drive_group(4'b1111, 1, 64'hB000);
        for (int i = 0; i < 4; i++) begin
            checks++; if (io_out_valid !== 1'b1 || io_out_dest !== 32'(i + 1) || io_out_data !== 64'hB000 + 64'(i))
                begin errors++; $display("FAIL order_%0d got v=%b d=%0d x=%h want d=%0d", i, io_out_valid, io_out_dest, io_out_data, i + 1); end
            @(posedge clock);
            #1;
        end
        checks++; if (io_count !== 5'd0) begin errors++; $display("FAIL order_count got %0d want 0", io_count); end
    endtask

    task automatic test_overflow_full();
        io_out_ready = 1'b0;
        for (int g = 0; g < 4; g++) drive_group(4'b1111, g * 4, 64'hA000 + 64'(g * 4));
        checks++; if (io_count !== 5'd16) begin errors++; $display("FAIL full_count got %0d want 16", io_count); end
        checks++; if (io_overflow !== 1'b0) begin errors++; $display("FAIL full_no_ovf got %b want 0", io_overflow); end
        drive_group(4'b0001, 31, 64'hDEAD);
        checks++; if (io_count !== 5'd16) begin errors++; $display("FAIL drop_count got %0d want 16", io_count); end
        checks++; if (io_overflow !== 1'b1) begin errors++; $display("FAIL drop_ovf got %b want 1", io_overflow); end
        io_out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            checks++; if (io_out_valid !== 1'b1 || io_out_dest !== 32'(i) || io_out_data !== 64'hA000 + 64'(i))
                begin errors++; $display("FAIL drain_%0d got v=%b d=%0d x=%h want d=%0d", i, io_out_valid, io_out_dest, io_out_data, i); end
            @(posedge clock);
            #1;
        end
        checks++; if (io_count !== 5'd0) begin errors++; $display("FAIL drain_count got %0d want 0", io_count); end
        checks++; if (io_overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", io_overflow); end
    endtask

    task automatic test_no_credit();
        do_reset();
        io_out_ready = 1'b0;
        drive_group(4'b1111, 0, 64'hC000);
        drive_group(4'b1111, 4, 64'hC004);
        drive_group(4'b1111, 8, 64'hC008);
        drive_group(4'b0111, 12, 64'hC00C);
        checks++; if (io_count !== 5'd15) begin errors++; $display("FAIL nc_fill got %0d want 15", io_count); end
        io_out_ready = 1'b1;
        drive_group(4'b0011, 30, 64'hEEEE);
        io_out_ready = 1'b0;
        checks++; if (io_count !== 5'd14) begin errors++; $display("FAIL nc_count got %0d want 14", io_count); end
        checks++; if (io_overflow !== 1'b1) begin errors++; $display("FAIL nc_ovf got %b want 1", io_overflow); end
        checks++; if (io_out_dest !== 32'd1 || io_out_data !== 64'hC001) begin errors++; $display("FAIL nc_head got d=%0d x=%h want d=1 x=c001", io_out_dest, io_out_data); end
    endtask

    task automatic test_wrap();
        do_reset();
        io_out_ready = 1'b0;
        for (int g = 0; g < 3; g++) drive_group(4'b1111, g * 4, 64'h0);
        drive_group(4'b0011, 12, 64'h0);
        io_out_ready = 1'b1;
        repeat (14) @(posedge clock);
        #1;
        checks++; if (io_count !== 5'd0) begin errors++; $display("FAIL wrap_pre got %0d want 0", io_count); end
        drive_group(4'b1111, 20, 64'hF000);
        for (int i = 0; i < 4; i++) begin
            checks++; if (io_out_valid !== 1'b1 || io_out_dest !== 32'(20 + i) || io_out_data !== 64'hF000 + 64'(i))
                begin errors++; $display("FAIL wrap_%0d got v=%b d=%0d x=%h want d=%0d", i, io_out_valid, io_out_dest, io_out_data, 20 + i); end
            @(posedge clock);
            #1;
        end
        checks++; if (io_out_valid !== 1'b0) begin errors++; $display("FAIL wrap_empty got %b want 0", io_out_valid); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        io_out_ready = 1'b0;
        for (int g = 0; g < 4; g++) drive_group(4'b1111, g * 4, 64'h0);
        drive_group(4'b0001, 31, 64'h0);
        io_out_ready = 1'b1;
        repeat (7) @(posedge clock);
        #1;
        io_out_ready = 1'b0;
        checks++; if (io_count !== 5'd9 || io_overflow !== 1'b1) begin errors++; $display("FAIL mid_pre got c=%0d o=%b want c=9 o=1", io_count, io_overflow); end
        #2;
        reset = 1'b1;
        #1;
        checks++; if (io_count !== 5'd0) begin errors++; $display("FAIL mid_count got %0d want 0", io_count); end
        checks++; if (io_out_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got %b want 0", io_out_valid); end
        checks++; if (io_overflow !== 1'b0) begin errors++; $display("FAIL mid_ovf got %b want 0", io_overflow); end
        @(negedge clock);
        reset = 1'b0;
        io_out_ready = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        checks++; if (io_out_valid !== 1'b0) begin errors++; $display("FAIL mid_quiet got %b want 0", io_out_valid); end
        drive_group(4'b0001, 9, 64'h1234);
        checks++; if (io_out_valid !== 1'b1 || io_out_dest !== 32'd9 || io_out_data !== 64'h1234)
            begin errors++; $display("FAIL mid_new got v=%b d=%0d x=%h want d=9 x=1234", io_out_valid, io_out_dest, io_out_data); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single();
        test_order();
        test_overflow_full();
        test_no_credit();
        test_wrap();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/difftest_fp_wb_serializer.md
DIFFTEST_FP_WB_SERIALIZER -- requirements
Module: difftest_fp_wb_serializer

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 4, number of FP writeback ports sampled per cycle.
REQ-002 SHALL have parameter DEPTH, default 16, FIFO entries; power of two, >= 2*NUM_PORTS.
REQ-003 SHALL have port clock, input, 1, sole clock; all state on rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-005 SHALL have port io_coreid, input, 8, hart id; passed through to io_out_coreid combinationally.
REQ-006 SHALL have port io_in_valid, input, NUM_PORTS, per-port writeback event strobe.
REQ-007 SHALL have port io_in_dest, input, NUM_PORTS x 5, FP architectural register index per port.
REQ-008 SHALL have port io_in_data, input, NUM_PORTS x 64, written value per port.
REQ-009 SHALL have port io_out_ready, input, 1, sink accepts the head event this cycle; the DPI sink ties it high.
REQ-010 SHALL have port io_out_valid, output, 1, head event present.
REQ-011 SHALL have port io_out_coreid, output, 8, copy of io_coreid.
REQ-012 SHALL have port io_out_dest, output, 32, head register index, zero-extended from 5 bits.
REQ-013 SHALL have port io_out_data, output, 64, head value.
REQ-014 SHALL have port io_count, output, clog2(DEPTH+1), current occupancy.
REQ-015 SHALL have port io_overflow, output, 1, sticky flag set when events were dropped.

Function
REQ-016 Each cycle SHALL enqueue all valid ports as one group, ascending port index, port 0 oldest.
REQ-017 Free space SHALL be DEPTH - io_count, sampled before this cycle's dequeue; a same-cycle dequeue gives no credit.
REQ-018 If popcount(io_in_valid) > free space, the whole group SHALL be dropped, io_overflow set next cycle, occupancy unchanged by enqueue.
REQ-019 io_out_valid SHALL equal (io_count != 0); head fields SHALL come straight from storage at the read pointer.
REQ-020 Dequeue SHALL occur when io_out_valid && io_out_ready; one entry per cycle maximum.
REQ-021 Minimum latency SHALL be 1 cycle: event enqueued at edge N is visible on io_out at cycle N+1.
REQ-022 Simultaneous enqueue k and dequeue SHALL update io_count by k-1.
REQ-023 Read/write pointers SHALL wrap modulo DEPTH; a group may straddle the wrap point.
REQ-024 io_out_dest/io_out_data SHALL be don't-care when io_out_valid is 0; the bench checks them only when valid.
REQ-025 io_overflow SHALL clear only on reset.

Reset
REQ-026 reset SHALL asynchronously force pointers to 0, io_count to 0, io_out_valid to 0 and io_overflow to 0; storage contents need not reset.
REQ-027 Reset asserted mid-operation SHALL discard all queued events; no event is output until new input after deassertion.

Configuration
REQ-028 With macro DIFFTEST_FPWB_OVERFLOW_ASSERT_EN defined, a simulation-only check SHALL report an error with the cycle and dropped count on every dropped group; without it, no check is compiled and only io_overflow records the drop.

Structure
REQ-029 Package difftest_fpwb_pkg SHALL hold the NUM_PORTS/DEPTH defaults, the 5-bit FP index width constant, and typedef fpwb_entry_t {dest[4:0], data[63:0]}.
REQ-030 One sub-module fpwb_fifo SHALL implement the multi-enqueue, single-dequeue circular buffer; the top holds compaction (popcount/prefix offsets), the drop decision and the overflow flag.

Verification
REQ-031 Reset, then a single event on port 2, dest=5, data=0x3FF0000000000000, ready=1 -> next cycle io_out_valid=1, io_out_dest=5, io_out_data matches; following cycle io_out_valid=0, io_count=0.
REQ-032 All 4 ports valid in one cycle, dests 1,2,3,4, ready=1 -> output order 1,2,3,4 on 4 consecutive cycles.
REQ-033 ready=0 while filling 16 entries, then a 1-event group -> group dropped, io_overflow=1, io_count=16; raise ready -> 16 original events drain in order.
REQ-034 Count 15, 2-event group with a same-cycle dequeue -> group dropped (no dequeue credit), io_count=14, io_overflow=1.
REQ-035 Pointers at 14, 4-event group -> entries occupy slots 14,15,0,1 and drain in order across the wrap.
REQ-036 reset asserted with io_count=9 -> io_count=0 and io_out_valid=0 immediately, without waiting for a clock edge; io_overflow=0.
